note_decoder: RTL and testbench

Receive-side counterpart of the guitar tone generator: it takes a square-wave tone input and measures its period in `clk` cycles. It classifies that period as one of the seven notes A–G, using the same 3-bit note code the tone generator consumes. It publishes the decoded note, a valid flag and a one-hot LED image. It sits behind the audio/tone input pin and feeds the LED bank and song-checking logic.

---
 rtl/note_decoder.sv | 171 +++++++++++++++++
 tb/tb_note_decoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_decoder.sv
// note_decoder: measures the period of a square-wave tone in clk cycles and
// classifies it as one of the notes A..G (codes 0..6). The decoded note, a
// lock flag, a one-hot LED image and a one-cycle change pulse are registered
// outputs.
//
// The period boundaries are parameters so the same logic can run at another
// clock rate; the defaults are the 25 MHz values.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no reference edge yet; counter parked at zero
//   ACQUIRE | counting periods, building up matches for a candidate note
//   LOCKED  | a note is confirmed; candidate logic keeps tracking changes
module note_decoder #(
    parameter int CONFIRM    = 2,
    parameter int TIMEOUT    = 250000,
    parameter int MIN_PERIOD = 60000,
    parameter int MAX_PERIOD = 120000,
    parameter int TH_A       = 107425,
    parameter int TH_B       = 98499,
    parameter int TH_C       = 90409,
    parameter int TH_D       = 80395,
    parameter int TH_E       = 73695,
    parameter int TH_F       = 67704
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tone_in,
    output logic [2:0] note,
    output logic       valid,
    output logic [6:0] led,
    output logic       new_note
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [19:0] TO_W   = 20'(TIMEOUT);
    localparam logic [19:0] MIN_W  = 20'(MIN_PERIOD);
    localparam logic [19:0] MAX_W  = 20'(MAX_PERIOD);
    localparam logic [19:0] TH_A_W = 20'(TH_A);
    localparam logic [19:0] TH_B_W = 20'(TH_B);
    localparam logic [19:0] TH_C_W = 20'(TH_C);
    localparam logic [19:0] TH_D_W = 20'(TH_D);
    localparam logic [19:0] TH_E_W = 20'(TH_E);
    localparam logic [19:0] TH_F_W = 20'(TH_F);
    localparam logic [2:0]  CONF_W = 3'(CONFIRM);

    state_t      state, state_nxt;
    logic        sync_a, sync_b, sync_d;
    logic        rise;
    logic [19:0] cnt, cnt_nxt;
    logic [2:0]  cand, cand_nxt;
    logic [2:0]  mcnt, mcnt_nxt;
    logic [2:0]  cur_note, cur_note_nxt;
    logic [2:0]  code;
    logic        code_ok;

    // two-flop synchroniser followed by a delay flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            sync_a <= tone_in;
            sync_b <= sync_a;
            sync_d <= sync_b;
        end
    end

    assign rise = sync_b & ~sync_d;

    // classify the running count; on a rise it equals the measured period
    always_comb begin
        code_ok = (cnt >= MIN_W) && (cnt <= MAX_W);
        if (cnt > TH_A_W)      code = 3'd0;
        else if (cnt > TH_B_W) code = 3'd1;
        else if (cnt > TH_C_W) code = 3'd2;
        else if (cnt > TH_D_W) code = 3'd3;
        else if (cnt > TH_E_W) code = 3'd4;
        else if (cnt > TH_F_W) code = 3'd5;
        else                   code = 3'd6;
    end

    // FSM state, period counter and candidate tracking registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            cand     <= '0;
            mcnt     <= '0;
            cur_note <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cand     <= cand_nxt;
            mcnt     <= mcnt_nxt;
            cur_note <= cur_note_nxt;
        end
    end

    // next-state: edges restart the counter and feed the candidate matcher;
    // an edge in the timeout cycle takes priority over the timeout
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cand_nxt     = cand;
        mcnt_nxt     = mcnt;
        cur_note_nxt = cur_note;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (rise) begin
                    cnt_nxt   = 20'd1;
                    state_nxt = ACQUIRE;
                end
            end
            ACQUIRE, LOCKED: begin
                if (rise) begin
                    cnt_nxt = 20'd1;
                    if (!code_ok) begin
                        mcnt_nxt = '0;
                    end else begin
                        if (code == cand) begin
                            // saturate at CONFIRM so a steady tone keeps confirming
                            if (mcnt < CONF_W) mcnt_nxt = mcnt + 3'd1;
                        end else begin
                            cand_nxt = code;
                            mcnt_nxt = 3'd1;
                        end
                        if (mcnt_nxt >= CONF_W) begin
                            cur_note_nxt = cand_nxt;
                            state_nxt    = LOCKED;
                        end
                    end
                end else if (cnt >= TO_W) begin
                    state_nxt = IDLE;
                    mcnt_nxt  = '0;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 20'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                mcnt_nxt  = '0;
            end
        endcase
    end

    // outputs trail the FSM by one cycle; pulse when lock is gained or the note moves
    always_ff @(posedge clk) begin
        if (reset) begin
            note     <= '0;
            valid    <= 1'b0;
            led      <= '0;
            new_note <= 1'b0;
        end else begin
            note     <= cur_note;
            valid    <= (state == LOCKED);
            led      <= (state == LOCKED) ? (7'b0000001 << cur_note) : 7'b0000000;
            new_note <= (state == LOCKED) && (!valid || (cur_note != note));
        end
    end

endmodule

// File: tb/tb_note_decoder.sv
// Bench for note_decoder. Periods are scaled down by ~100x through the
// boundary parameters so whole lock/timeout sequences fit in a short run.
// A per-cycle reference model works on absolute rise times and the spec's
// classification table; directed checks cover the headline behaviours.
module tb_note_decoder;

    localparam int CONFIRM = 2;
    localparam int TIMEOUT = 2500;
    localparam int MINP    = 600;
    localparam int MAXP    = 1200;
    localparam int TH_A    = 1074;
    localparam int TH_B    = 984;
    localparam int TH_C    = 904;
    localparam int TH_D    = 803;
    localparam int TH_E    = 736;
    localparam int TH_F    = 677;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tone_in = 1'b0;
    logic [2:0] note;
    logic       valid;
    logic [6:0] led;
    logic       new_note;

    always #5 clk = ~clk;

    note_decoder #(
        .CONFIRM(CONFIRM), .TIMEOUT(TIMEOUT), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP),
        .TH_A(TH_A), .TH_B(TH_B), .TH_C(TH_C), .TH_D(TH_D), .TH_E(TH_E), .TH_F(TH_F)
    ) dut (
        .clk(clk), .reset(reset), .tone_in(tone_in),
        .note(note), .valid(valid), .led(led), .new_note(new_note)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // reference model state: absolute step numbers, no counters
    int   step_n = 0;
    logic h0 = 0, h1 = 0, h2 = 0, h3 = 0;
    bit   m_ref = 0;
    int   m_last = 0;
    int   m_cand = 0, m_mcnt = 0, m_note = 0;
    bit   m_lock = 0;
    int   e_note = 0, e_valid = 0, e_led = 0, e_nn = 0;

    // monitors
    logic prev_t = 0, prev_nn = 0, prev_valid = 0;
    int   last_rise = 0, vr_step = 0, vf_step = 0, vf_cnt = 0;
    int   pulses = 0, consec = 0;

    function automatic int classify(input int p);
        if (p < MINP || p > MAXP) return -1;
        if (p > TH_A) return 0;
        if (p > TH_B) return 1;
        if (p > TH_C) return 2;
        if (p > TH_D) return 3;
        if (p > TH_E) return 4;
        if (p > TH_F) return 5;
        return 6;
    endfunction

    function automatic logic [31:0] outs();
        return {20'd0, note, valid, led, new_note};
    endfunction

    task automatic model(input int k, input logic t, input logic r);
        int p, c;
        if (r) begin
            h0 = 0; h1 = 0; h2 = 0; h3 = 0;
            m_ref = 0; m_last = 0; m_cand = 0; m_mcnt = 0; m_note = 0; m_lock = 0;
            e_note = 0; e_valid = 0; e_led = 0; e_nn = 0;
            return;
        end
        // outputs show the decision made one step earlier
        e_nn    = (m_lock && (e_valid == 0 || m_note != e_note)) ? 1 : 0;
        e_valid = m_lock ? 1 : 0;
        e_note  = m_note;
        e_led   = m_lock ? (1 << m_note) : 0;
        // a rise applied at step k acts at step k+2
        h3 = h2; h2 = h1; h1 = h0; h0 = t;
        if (h2 && !h3) begin
            if (!m_ref) begin
                m_ref  = 1;
                m_last = k;
            end else begin
                p      = k - m_last;
                m_last = k;
                c      = classify(p);
                if (c < 0) begin
                    m_mcnt = 0;
                end else begin
                    if (c == m_cand) m_mcnt++;
                    else begin m_cand = c; m_mcnt = 1; end
                    if (m_mcnt >= CONFIRM) begin
                        m_note = m_cand;
                        m_lock = 1;
                    end
                end
            end
        end else if (m_ref && (k - m_last) == TIMEOUT) begin
            m_ref  = 0;
            m_lock = 0;
            m_mcnt = 0;
        end
    endtask

    task automatic step(input logic t, input logic r);
        int k;
        step_n++;
        k = step_n;
        @(negedge clk);
        tone_in = t;
        reset   = r;
        if (t && !prev_t) last_rise = k;
        prev_t = t;
        @(posedge clk);
        #1;
        model(k, t, r);
        check("outputs", outs(), 32'((e_note << 9) | (e_valid << 8) | (e_led << 1) | e_nn));
        if (new_note && prev_nn) consec++;
        if (new_note) pulses++;
        if (valid && !prev_valid) vr_step = k;
        if (!valid && prev_valid) begin vf_step = k; vf_cnt++; end
        prev_nn    = new_note;
        prev_valid = valid;
    endtask

    task automatic tone(input int per, input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < per / 2; j++) step(1'b1, 1'b0);
            for (int j = 0; j < per - per / 2; j++) step(1'b0, 1'b0);
        end
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    int start, vfc, tie_ref;
    int bper [3] = '{1074, 1075, 677};
    int bexp [3] = '{1, 0, 6};
    int nper [2] = '{599, 1201};

    initial begin
        // reset then silence
        do_reset(3);
        check("reset_outs", outs(), 32'd0);
        pulses = 0;
        quiet(2600);
        check("idle_pulses", 32'(pulses), 32'd0);
        check("idle_outs", outs(), 32'd0);

        // tone A: lock after reference + 2 periods, one pulse only
        pulses = 0;
        start = step_n + 1;
        tone(1136, 7);
        check("A_latency", 32'(vr_step - start), 32'(2 * 1136 + 3));
        check("A_note", 32'(note), 32'd0);
        check("A_led", 32'(led), 32'h01);
        check("A_pulses", 32'(pulses), 32'd1);

        // switch to G while locked
        pulses = 0;
        vfc = vf_cnt;
        tone(637, 5);
        check("G_note", 32'(note), 32'd6);
        check("G_led", 32'(led), 32'h40);
        check("G_pulses", 32'(pulses), 32'd1);
        check("G_valid_held", 32'(vf_cnt - vfc), 32'd0);

        // boundary periods that lock
        for (int i = 0; i < 3; i++) begin
            do_reset(1);
            quiet(5);
            tone(bper[i], 4);
            check("bound_valid", 32'(valid), 32'd1);
            check("bound_note", 32'(note), 32'(bexp[i]));
        end
        // out-of-range periods never lock
        for (int i = 0; i < 2; i++) begin
            do_reset(1);
            pulses = 0;
            tone(nper[i], 5);
            check("range_valid", 32'(valid), 32'd0);
            check("range_pulses", 32'(pulses), 32'd0);
        end

        // D: lock, stop, timeout, relock
        do_reset(1);
        tone(850, 4);
        check("D_note", 32'(note), 32'd3);
        quiet(TIMEOUT + 100);
        check("D_timeout_lat", 32'(vf_step - last_rise), 32'(2 + TIMEOUT + 1));
        check("D_note_held", 32'(note), 32'd3);
        check("D_valid_led", 32'({valid, led}), 32'd0);
        pulses = 0;
        start = step_n + 1;
        tone(850, 4);
        check("D_relock_lat", 32'(vr_step - start), 32'(2 * 850 + 3));
        check("D_relock_pulses", 32'(pulses), 32'd1);

        // edge landing exactly on the timeout cycle keeps the lock
        tie_ref = last_rise;
        vfc = vf_cnt;
        while (step_n + 1 < tie_ref + TIMEOUT) step(1'b0, 1'b0);
        tone(850, 3);
        check("tie_valid_held", 32'(vf_cnt - vfc), 32'd0);
        check("tie_note", 32'(note), 32'd3);

        // E: reset mid-period
        do_reset(1);
        tone(757, 4);
        check("E_note", 32'(note), 32'd4);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("E_reset_outs", outs(), 32'd0);
        quiet(300);
        start = step_n + 1;
        tone(757, 4);
        check("E_relock_lat", 32'(vr_step - start), 32'(2 * 757 + 3));
        check("E_led", 32'(led), 32'h10);

        // random periods, some out of range, occasional silence
        for (int i = 0; i < 10; i++) begin
            tone($urandom_range(1250, 550), $urandom_range(2, 1));
            if ($urandom_range(5, 0) == 0) quiet(TIMEOUT + 20);
        end

        check("no_consec_pulses", 32'(consec), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
